// File: rtl/sd_sector_responder.sv
// Responder side of the SD sector interface: serves 512-byte sd_rd/sd_wr transfers against a byte-wide backing memory, and pulses img_mounted on a mount edge.
// Each byte takes a fetch or store handshake plus GAP idle clocks. mem_rd/mem_wr are held until mem_ack, so a slow memory simply stretches the transfer.
module sd_sector_responder #(
    parameter int ADDR_W      = 20,
    parameter int IMG_SECTORS = 1440,
    parameter int GAP         = 4,
    parameter int DIN_LAT     = 2
) (
    input  logic              clk_sys,
    input  logic              res_n,
    input  logic              mount,
    output logic              img_mounted,
    output logic [31:0]       img_size,
    input  logic [31:0]       sd_lba,
    input  logic              sd_rd,
    input  logic              sd_wr,
    output logic              sd_ack,
    output logic [8:0]        sd_buff_addr,
    output logic [7:0]        sd_dout,
    output logic              sd_dout_strobe,
    input  logic [7:0]        sd_din,
    output logic              sd_din_strobe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic              err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_FETCH,
        S_RD_PUT,
        S_RD_GAP,
        S_WR_ADDR,
        S_WR_SAMPLE,
        S_WR_STORE,
        S_WR_GAP,
        S_DONE
    } state_t;

    localparam int CNT_W = 16;
    // The address phase always lasts at least one clock, even when DIN_LAT is 0.
    localparam int DIN_WAIT = (DIN_LAT < 1) ? 1 : DIN_LAT;
    localparam logic [CNT_W-1:0] DIN_LAST = CNT_W'(DIN_WAIT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP > 0) ? GAP - 1 : 0);

    state_t           state_q, state_d;
    logic [31:0]      lba_q, lba_d;
    logic             oor_q, oor_d;
    logic             armed_q, armed_d;
    logic [8:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [8:0]       buff_addr_q, buff_addr_d;
    logic [7:0]       dout_q, dout_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             mount_q;
    logic             mounted_q;

    logic advance;
    logic adv_rd;

    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            state_q     <= S_IDLE;
            lba_q       <= '0;
            oor_q       <= 1'b0;
            armed_q     <= 1'b1;
            idx_q       <= '0;
            cnt_q       <= '0;
            buff_addr_q <= '0;
            dout_q      <= '0;
            wdata_q     <= '0;
            mount_q     <= 1'b0;
            mounted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lba_q       <= lba_d;
            oor_q       <= oor_d;
            armed_q     <= armed_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            buff_addr_q <= buff_addr_d;
            dout_q      <= dout_d;
            wdata_q     <= wdata_d;
            mount_q     <= mount;
            mounted_q   <= mount & ~mount_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        lba_d       = lba_q;
        oor_d       = oor_q;
        armed_d     = armed_q;
        idx_d       = idx_q;
        cnt_d       = '0;
        buff_addr_d = buff_addr_q;
        dout_d      = dout_q;
        wdata_d     = wdata_q;
        advance     = 1'b0;
        adv_rd      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (armed_q && (sd_rd || sd_wr)) begin
                    lba_d   = sd_lba;
                    oor_d   = (sd_lba >= 32'(IMG_SECTORS));
                    armed_d = 1'b0;
                    idx_d   = '0;
                    if (sd_rd) begin
                        state_d = S_RD_FETCH;
                    end else begin
                        state_d     = S_WR_ADDR;
                        buff_addr_d = '0;
                    end
                end else if (!sd_rd && !sd_wr) begin
                    armed_d = 1'b1;
                end
            end
            S_RD_FETCH: begin
                if (oor_q || mem_ack) begin
                    dout_d      = oor_q ? 8'h00 : mem_rdata;
                    buff_addr_d = idx_q;
                    state_d     = S_RD_PUT;
                end
            end
            S_RD_PUT: begin
                if (GAP == 0) begin
                    advance = 1'b1;
                    adv_rd  = 1'b1;
                end else begin
                    state_d = S_RD_GAP;
                end
            end
            S_RD_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    advance = 1'b1;
                    adv_rd  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WR_ADDR: begin
                if (cnt_q == DIN_LAST) begin
                    state_d = S_WR_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WR_SAMPLE: begin
                wdata_d = sd_din;
                state_d = S_WR_STORE;
            end
            S_WR_STORE: begin
                if (oor_q || mem_ack) begin
                    if (GAP == 0) begin
                        advance = 1'b1;
                    end else begin
                        state_d = S_WR_GAP;
                    end
                end
            end
            S_WR_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Byte finished: either close the sector or move to the next index.
        if (advance) begin
            if (idx_q == 9'd511) begin
                state_d = S_DONE;
            end else begin
                idx_d = idx_q + 9'd1;
                if (adv_rd) begin
                    state_d = S_RD_FETCH;
                end else begin
                    state_d     = S_WR_ADDR;
                    buff_addr_d = idx_q + 9'd1;
                end
            end
        end
    end

    assign mem_rd         = (state_q == S_RD_FETCH) && !oor_q;
    assign mem_wr         = (state_q == S_WR_STORE) && !oor_q;
    assign mem_addr       = (mem_rd || mem_wr) ? ADDR_W'({lba_q, idx_q}) : '0;
    assign mem_wdata      = wdata_q;
    assign sd_ack         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign sd_buff_addr   = buff_addr_q;
    assign sd_dout        = dout_q;
    assign sd_dout_strobe = (state_q == S_RD_PUT);
    assign sd_din_strobe  = (state_q == S_WR_SAMPLE);
    assign err            = (state_q == S_DONE) && oor_q;
    assign img_mounted    = mounted_q;
    assign img_size       = 32'(IMG_SECTORS * 512);

endmodule

// File: tb/tb_sd_sector_responder.sv
// Directed bench for sd_sector_responder: behavioural memory, core din pipeline, negedge monitor.
module tb_sd_sector_responder;

    localparam int GAP     = 4;
    localparam int DIN_LAT = 2;

    logic        clk_sys = 1'b0;
    logic        res_n   = 1'b0;
    logic        mount   = 1'b0;
    logic [31:0] sd_lba  = '0;
    logic        sd_rd   = 1'b0;
    logic        sd_wr   = 1'b0;
    logic [7:0]  sd_din  = '0;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ack = 1'b0;

    logic        img_mounted;
    logic [31:0] img_size;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_dout;
    logic        sd_dout_strobe;
    logic        sd_din_strobe;
    logic [19:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic        err;

    sd_sector_responder #(
        .ADDR_W(20), .IMG_SECTORS(1440), .GAP(GAP), .DIN_LAT(DIN_LAT)
    ) dut (
        .clk_sys(clk_sys), .res_n(res_n), .mount(mount),
        .img_mounted(img_mounted), .img_size(img_size),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_dout(sd_dout), .sd_dout_strobe(sd_dout_strobe),
        .sd_din(sd_din), .sd_din_strobe(sd_din_strobe),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
    );

    always #5 clk_sys = ~clk_sys;

    int n_asserts = 0;
    int n_fail    = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Backing memory with 1..7 clock acknowledge latency.
    logic [7:0] mem [0:(1<<20)-1];
    int mem_lat  = 1;
    bit rand_lat = 1'b0;
    int lat;

    initial forever begin
        @(negedge clk_sys);
        if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (res_n && (mem_rd || mem_wr)) begin
            lat = rand_lat ? int'($urandom_range(7, 1)) : mem_lat;
            repeat (lat - 1) @(negedge clk_sys);
            if (res_n && (mem_rd || mem_wr)) begin
                mem_ack = 1'b1;
                if (mem_rd) mem_rdata = mem[mem_addr];
                else        mem[mem_addr] = mem_wdata;
            end
        end
    end

    // Core sector buffer: byte[i] = ~i, returned DIN_LAT clocks after the address.
    logic [7:0] din_d1 = '0;
    initial forever begin
        @(posedge clk_sys);
        #1;
        sd_din = din_d1;
        din_d1 = ~sd_buff_addr[7:0];
    end

    // Monitor: sole writer of the per-transfer counters.
    int cyc = 0, last_wr = 0, exp_idx = 0, first_addr = -1;
    int n_rd = 0, n_wr = 0, n_memrd = 0, n_memwr = 0, n_err = 0, n_mount = 0, n_ack = 0;
    int seq_err = 0, data_err = 0, spc_err = 0, both_err = 0;
    int clr_tok = 0, clr_seen = 0;
    bit exp_zero = 1'b0;

    always @(negedge clk_sys) begin
        cyc++;
        if (clr_tok != clr_seen) begin
            clr_seen = clr_tok;
            exp_idx = 0; first_addr = -1;
            n_rd = 0; n_wr = 0; n_memrd = 0; n_memwr = 0; n_err = 0; n_mount = 0; n_ack = 0;
            seq_err = 0; data_err = 0; spc_err = 0;
        end
        if (sd_dout_strobe) begin
            if (first_addr < 0) first_addr = int'(sd_buff_addr);
            if (int'(sd_buff_addr) != exp_idx) seq_err++;
            if (sd_dout != (exp_zero ? 8'h00 : (sd_buff_addr[7:0] ^ 8'h5A))) data_err++;
            exp_idx++;
            n_rd++;
        end
        if (sd_din_strobe) begin
            if (int'(sd_buff_addr) != exp_idx) seq_err++;
            if (n_wr > 0 && (cyc - last_wr) < DIN_LAT + GAP + 1) spc_err++;
            last_wr = cyc;
            exp_idx++;
            n_wr++;
        end
        if (mem_rd) n_memrd++;
        if (mem_wr) n_memwr++;
        if (mem_rd && mem_wr) both_err++;
        if (err) n_err++;
        if (img_mounted) n_mount++;
        if (sd_ack) n_ack++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_sys);
            #2;
        end
    endtask

    task automatic clr();
        clr_tok++;
        tick(2);
    endtask

    task automatic start_xfer(input string tag, input bit rd, input bit wr, input logic [31:0] lba);
        clr();
        sd_lba = lba;
        sd_rd  = rd;
        sd_wr  = wr;
        tick();
        check_eq({tag, "_ack_rise"}, sd_ack, 1);
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (sd_ack && k < 10000) begin
            tick();
            k++;
        end
        check_eq({tag, "_timeout"}, (k >= 10000) ? 1 : 0, 0);
        tick(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int k;
        for (int i = 0; i < 512; i++) begin
            mem[i]        = 8'(i) ^ 8'h5A;
            mem[3*512+i]  = 8'(i) ^ 8'h5A;
            mem[10*512+i] = 8'(i);
        end

        // Reset state
        tick(2);
        check_eq("rst_ack", sd_ack, 0);
        check_eq("rst_mem_rd", mem_rd, 0);
        check_eq("rst_strobes", {sd_dout_strobe, sd_din_strobe}, 0);
        check_eq("rst_buff_addr", sd_buff_addr, 0);
        check_eq("rst_err_mount", {err, img_mounted}, 0);
        check_eq("img_size_rst", img_size, 737280);
        res_n = 1'b1;
        tick(2);
        check_eq("idle_outputs", {sd_ack, mem_rd, mem_wr, err, img_mounted}, 0);

        // Mount edge gives a single-cycle pulse on the following clock
        clr();
        mount = 1'b1;
        tick();
        check_eq("mount_pulse_hi", img_mounted, 1);
        tick();
        check_eq("mount_pulse_lo", img_mounted, 0);
        tick(3);
        mount = 1'b0;
        tick(2);
        check_eq("mount_count", n_mount, 1);

        // In-range read of sector 3, request level held afterwards
        exp_zero = 1'b0;
        start_xfer("rd3", 1, 0, 32'd3);
        wait_done("rd3");
        check_eq("rd3_strobes", n_rd, 512);
        check_eq("rd3_seq", seq_err, 0);
        check_eq("rd3_data", data_err, 0);
        check_eq("rd3_err", n_err, 0);
        clr();
        tick(40);
        check_eq("rd3_held_no_rerun", n_ack, 0);
        sd_rd = 1'b0;
        tick(2);

        // In-range write of sector 10
        start_xfer("wr10", 0, 1, 32'd10);
        wait_done("wr10");
        sd_wr = 1'b0;
        check_eq("wr10_strobes", n_wr, 512);
        check_eq("wr10_seq", seq_err, 0);
        check_eq("wr10_spacing", spc_err, 0);
        check_eq("wr10_memwr", n_memwr, 512);
        check_eq("wr10_err", n_err, 0);
        bad = 0;
        for (int i = 0; i < 512; i++)
            if (mem[5120+i] !== ~8'(i)) bad++;
        check_eq("wr10_mem_content", bad, 0);
        tick(2);

        // Out-of-range read
        exp_zero = 1'b1;
        start_xfer("rd1440", 1, 0, 32'd1440);
        wait_done("rd1440");
        sd_rd = 1'b0;
        check_eq("rd1440_strobes", n_rd, 512);
        check_eq("rd1440_zero_data", data_err, 0);
        check_eq("rd1440_no_memrd", n_memrd, 0);
        check_eq("rd1440_err", n_err, 1);
        exp_zero = 1'b0;
        tick(2);

        // Out-of-range write
        start_xfer("wr2000", 0, 1, 32'd2000);
        wait_done("wr2000");
        sd_wr = 1'b0;
        check_eq("wr2000_strobes", n_wr, 512);
        check_eq("wr2000_no_memwr", n_memwr, 0);
        check_eq("wr2000_err", n_err, 1);
        tick(2);

        // Both requests together: read wins, then a write-only request
        start_xfer("both", 1, 1, 32'd0);
        wait_done("both");
        check_eq("both_rd_strobes", n_rd, 512);
        check_eq("both_no_wr", n_wr, 0);
        check_eq("both_data", data_err, 0);
        sd_rd = 1'b0;
        sd_wr = 1'b0;
        tick(2);
        start_xfer("wr0", 0, 1, 32'd0);
        wait_done("wr0");
        sd_wr = 1'b0;
        check_eq("wr0_strobes", n_wr, 512);
        check_eq("wr0_no_rd", n_rd, 0);
        check_eq("wr0_mem0", mem[0], 8'hFF);
        check_eq("wr0_mem511", mem[511], 8'h00);
        tick(2);

        // Reset at byte 100 of a read with random memory latency
        rand_lat = 1'b1;
        start_xfer("rdrst", 1, 0, 32'd3);
        k = 0;
        while (n_rd < 100 && k < 5000) begin
            tick();
            k++;
        end
        check_eq("rdrst_reach_100", (k >= 5000) ? 1 : 0, 0);
        #1;
        res_n = 1'b0;
        #1;
        check_eq("rdrst_async_ack", sd_ack, 0);
        check_eq("rdrst_async_mem", {mem_rd, mem_wr}, 0);
        check_eq("rdrst_async_addr", sd_buff_addr, 0);
        check_eq("rdrst_async_dout", sd_dout, 0);
        sd_rd = 1'b0;
        clr();
        tick(5);
        check_eq("rdrst_quiet", n_rd + n_memrd, 0);
        res_n = 1'b1;
        tick(12);
        start_xfer("rdre", 1, 0, 32'd3);
        wait_done("rdre");
        sd_rd = 1'b0;
        check_eq("rdre_first_addr", first_addr, 0);
        check_eq("rdre_strobes", n_rd, 512);
        check_eq("rdre_seq", seq_err, 0);
        check_eq("rdre_data", data_err, 0);

        check_eq("never_rd_and_wr", both_err, 0);
        check_eq("img_size_const", img_size, 737280);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
